e_mult_div_unit: RTL and testbench

//  Execute-stage HI/LO multiply/divide unit. It consumes the decoder's MDOp/MD_start fields and the forwarded rs/rt

---
 rtl/e_mult_div_unit_pkg.sv | 26 ++
 rtl/e_mult_div_unit.sv | 128 ++++++++++++
 tb/tb_e_mult_div_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/e_mult_div_unit_pkg.sv
// Shared encodings for the execute-stage HI/LO multiply/divide unit:
// MDOp operation codes, FSM states and default latencies.
package e_mult_div_unit_pkg;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;
    localparam int CNT_W           = 4;

    typedef enum logic [3:0] {
        MD_ELSE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/e_mult_div_unit.sv
// Execute-stage HI/LO unit: mult/multu/div/divu with fixed latency,
// mthi/mtlo writes and mfhi/mflo reads.
// Ports: clk, reset (sync, active-high), req (flush), MD_start, MDOp[3:0],
//        A/B[31:0] operands; HI/LO[31:0] registers, MD_out[31:0], busy.
module e_mult_div_unit
    import e_mult_div_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        MD_start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MD_out,
    output logic        busy
);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;

    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;

    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'h0, A} * {32'h0, B};

    // Divider outputs are only consumed when B is nonzero.
    always_comb begin
        quo_s = '0;
        rem_s = '0;
        quo_u = '0;
        rem_u = '0;
        if (B != 32'h0) begin
            quo_s = $signed(A) / $signed(B);
            rem_s = $signed(A) % $signed(B);
            quo_u = A / B;
            rem_u = A % B;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            hi_tmp_q <= hi_tmp_d;
            lo_tmp_q <= lo_tmp_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_tmp_d = hi_tmp_q;
        lo_tmp_d = lo_tmp_q;
        unique case (state_q)
            S_IDLE: begin
                if (!req && MD_start) begin
                    case (MDOp)
                        MD_MULT: begin
                            {hi_tmp_d, lo_tmp_d} = prod_s;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        MD_MULTU: begin
                            {hi_tmp_d, lo_tmp_d} = prod_u;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            state_d = S_BUSY;
                        end
                        MD_DIV, MD_DIVU: begin
                            // Divide by zero re-commits the current HI/LO.
                            hi_tmp_d = hi_q;
                            lo_tmp_d = lo_q;
                            if (B != 32'h0) begin
                                hi_tmp_d = (MDOp == MD_DIV) ? rem_s : rem_u;
                                lo_tmp_d = (MDOp == MD_DIV) ? quo_s : quo_u;
                            end
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            state_d = S_BUSY;
                        end
                        default: ;
                    endcase
                end else if (!req) begin
                    if (MDOp == MD_MTHI) hi_d = A;
                    if (MDOp == MD_MTLO) lo_d = A;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    hi_d    = hi_tmp_q;
                    lo_d    = lo_tmp_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        MD_out = 32'h0;
        if (MDOp == MD_MFHI) MD_out = hi_q;
        if (MDOp == MD_MFLO) MD_out = lo_q;
    end

    assign HI   = hi_q;
    assign LO   = lo_q;
    assign busy = (state_q == S_BUSY);

endmodule

// File: tb/tb_e_mult_div_unit.sv
// Bench for e_mult_div_unit: directed vector table, corner sequences and
// random operations against an arithmetic reference model.
module tb_e_mult_div_unit;
    import e_mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset, req, MD_start, busy;
    logic [3:0]  MDOp;
    logic [31:0] A, B, HI, LO, MD_out;

    int tests = 0;
    int fails = 0;
    logic [31:0] mhi, mlo;

    e_mult_div_unit dut (
        .clk(clk), .reset(reset), .req(req), .MD_start(MD_start),
        .MDOp(MDOp), .A(A), .B(B), .HI(HI), .LO(LO),
        .MD_out(MD_out), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, hi, lo;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] ref_md(input logic [3:0] op,
            input logic [31:0] a, input logic [31:0] b,
            input logic [31:0] hi, input logic [31:0] lo);
        longint sa, sb;
        longint unsigned ua, ub;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        case (op)
            MD_MULT:  begin p = sa * sb; return p; end
            MD_MULTU: return ua * ub;
            MD_DIV:   if (b == 0) return {hi, lo};
                      else return {32'(sa % sb), 32'(sa / sb)};
            MD_DIVU:  if (b == 0) return {hi, lo};
                      else return {32'(ua % ub), 32'(ua / ub)};
            default:  return {hi, lo};
        endcase
    endfunction

    task automatic run_op(input string nm, input logic [3:0] op,
            input logic [31:0] a, input logic [31:0] b,
            input logic [31:0] eh, input logic [31:0] el);
        int n;
        n = (op == MD_MULT || op == MD_MULTU) ? MULT_CYCLES_DEF : DIV_CYCLES_DEF;
        MD_start = 1'b1; MDOp = op; A = a; B = b;
        step();
        MD_start = 1'b0; MDOp = MD_ELSE; A = $urandom; B = $urandom;
        for (int i = 0; i < n; i++) begin
            chk({nm, " busy"}, {31'h0, busy}, 32'h1);
            if (i == n - 1) chk({nm, " old_hi"}, HI, mhi);
            step();
        end
        chk({nm, " done"}, {31'h0, busy}, 32'h0);
        chk({nm, " hi"}, HI, eh);
        chk({nm, " lo"}, LO, el);
        mhi = eh;
        mlo = el;
    endtask

    initial begin
        vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[1] = '{MD_DIVU,  32'd100, 32'd7, 32'd2, 32'd14};
        vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
        vecs[4] = '{MD_DIV,   32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
        vecs[5] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0};

        reset = 1'b1; req = 1'b0; MD_start = 1'b0; MDOp = MD_ELSE;
        A = '0; B = '0;
        step();
        step();
        reset = 1'b0;
        chk("rst hi", HI, 32'h0);
        chk("rst lo", LO, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst md_out", MD_out, 32'h0);
        mhi = '0;
        mlo = '0;

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].hi, vecs[i].lo);

        MDOp = MD_MTHI; A = 32'h1234;
        step();
        mhi = 32'h1234;
        chk("mthi busy", {31'h0, busy}, 32'h0);
        MDOp = MD_MFHI; #1;
        chk("mfhi", MD_out, 32'h1234);
        MDOp = MD_MFLO; #1;
        chk("mflo", MD_out, mlo);
        MDOp = MD_ELSE; #1;
        chk("else out", MD_out, 32'h0);
        req = 1'b1; MDOp = MD_MTHI; A = 32'hDEAD;
        step();
        req = 1'b0;
        chk("req mthi", HI, 32'h1234);
        MDOp = MD_MTLO; A = 32'h5678;
        step();
        mlo = 32'h5678;
        MDOp = MD_ELSE;
        chk("mtlo", LO, 32'h5678);

        req = 1'b1; MD_start = 1'b1; MDOp = MD_MULT; A = 2; B = 2;
        step();
        req = 1'b0; MD_start = 1'b0; MDOp = MD_ELSE;
        chk("req start busy", {31'h0, busy}, 32'h0);
        step();
        chk("req start lo", LO, mlo);

        MDOp = MD_MTHI; A = 5;
        step();
        MDOp = MD_MTLO; A = 9;
        step();
        mhi = 5; mlo = 9;
        run_op("div0", MD_DIV, 32'd123, 32'd0, 32'd5, 32'd9);

        MD_start = 1'b1; MDOp = MD_DIVU; A = 100; B = 7;
        step();
        for (int i = 0; i < DIV_CYCLES_DEF; i++) begin
            chk("ign busy", {31'h0, busy}, 32'h1);
            MD_start = (i == 2); MDOp = (i == 2) ? MD_MULT : MD_ELSE;
            A = 3; B = 3;
            step();
        end
        MD_start = 1'b0; MDOp = MD_ELSE;
        chk("ign done", {31'h0, busy}, 32'h0);
        chk("ign hi", HI, 32'd2);
        chk("ign lo", LO, 32'd14);
        step();
        chk("ign idle", {31'h0, busy}, 32'h0);
        mhi = 2; mlo = 14;

        for (int k = 0; k < 40; k++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            logic [63:0] r;
            case ($urandom_range(0, 3))
                0: op = MD_MULT;
                1: op = MD_MULTU;
                2: op = MD_DIV;
                default: op = MD_DIVU;
            endcase
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = $urandom_range(1, 50);
                default: b = $urandom;
            endcase
            if (op == MD_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 1;
            r = ref_md(op, a, b, mhi, mlo);
            run_op($sformatf("rnd%0d", k), op, a, b, r[63:32], r[31:0]);
        end

        MD_start = 1'b1; MDOp = MD_MULT; A = 6; B = 7;
        step();
        MD_start = 1'b0; MDOp = MD_ELSE;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort hi", HI, 32'h0);
        chk("abort lo", LO, 32'h0);
        repeat (6) step();
        chk("abort late hi", HI, 32'h0);
        chk("abort late lo", LO, 32'h0);
        chk("abort late busy", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
